// File: rtl/bcd_count_display.sv
// BCD event counter with a rippling carry (one digit per clk) and a serial 7-segment
// frame driver that shifts a snapshot of the count into an external shift/latch chain.
module bcd_count_display #(
    parameter int DIGITS  = 6,
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_pulse,
    input  logic [DIGITS-1:0]     inc_sel,
    input  logic                  ref_pulse,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  overflow,
    output logic                  ser_data,
    output logic                  ser_clk,
    output logic                  ser_latch,
    output logic                  busy
);

    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BITS  = 8 * DIGITS;
    localparam int BIT_W = $clog2(BITS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [0:0] C_IDLE  = 1'b0;
    localparam logic [0:0] C_ADD   = 1'b1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOW   = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    function automatic logic [PTR_W-1:0] lowest_set(input logic [DIGITS-1:0] sel);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (sel[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

    // Segment byte {dp,g,f,e,d,c,b,a}, active high, dp always off
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    logic [0:0]          c_state_r, c_next_s;
    logic [PTR_W-1:0]    ptr_r, ptr_next_s;
    logic [4*DIGITS-1:0] count_r, count_next_s;
    logic                overflow_r, overflow_next_s;
    logic [PTR_W+1:0]    dig_idx_s;
    logic [3:0]          cur_digit_s;
    logic                inc_go_s;

    logic [1:0]          s_state_r, s_next_s;
    logic [DIV_W-1:0]    div_r, div_next_s;
    logic [BIT_W-1:0]    bit_r, bit_next_s;
    logic [BITS-1:0]     sreg_r, sreg_next_s;
    logic [BITS-1:0]     snapshot_s;
    logic                div_done_s;
    logic                start_s;
    logic                ref_pend_r, ref_pend_next_s;

    logic                ser_data_r, ser_clk_r, ser_latch_r, busy_r;

    assign inc_go_s    = inc_pulse & (|inc_sel);
    assign dig_idx_s   = {ptr_r, 2'b00};
    assign cur_digit_s = count_r[dig_idx_s +: 4];

    // Carry FSM: one digit examined per cycle, starting at the lowest selected digit
    always_comb begin
        c_next_s        = c_state_r;
        ptr_next_s      = ptr_r;
        count_next_s    = count_r;
        overflow_next_s = overflow_r;
        case (c_state_r)
            C_IDLE: begin
                if (inc_go_s) begin
                    ptr_next_s = lowest_set(inc_sel);
                    c_next_s   = C_ADD;
                end else begin
                    c_next_s   = C_IDLE;
                end
            end
            C_ADD: begin
                if (cur_digit_s < 4'd9) begin
                    count_next_s[dig_idx_s +: 4] = cur_digit_s + 4'd1;
                    c_next_s = C_IDLE;
                end else begin
                    count_next_s[dig_idx_s +: 4] = 4'd0;
                    if (ptr_r == PTR_W'(DIGITS - 1)) begin
                        overflow_next_s = 1'b1;
                        c_next_s        = C_IDLE;
                    end else begin
                        ptr_next_s = ptr_r + PTR_W'(1);
                    end
                end
            end
            default: c_next_s = C_IDLE;
        endcase
    end

    // Snapshot of every digit, most significant digit in the top byte
    always_comb begin
        snapshot_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            snapshot_s[8*i +: 8] = seg7(count_r[4*i +: 4]);
        end
    end

    // A refresh may start only when both FSMs idle; a same-cycle increment takes priority
    always_comb begin
        start_s = (ref_pulse | ref_pend_r) & (c_state_r == C_IDLE) &
                  (s_state_r == S_IDLE) & ~inc_go_s;
        if (start_s) begin
            ref_pend_next_s = 1'b0;
        end else if (ref_pulse) begin
            ref_pend_next_s = 1'b1;
        end else begin
            ref_pend_next_s = ref_pend_r;
        end
    end

    // Shifter FSM: low/high half-periods per bit, then a latch strobe
    always_comb begin
        s_next_s    = s_state_r;
        div_next_s  = div_r;
        bit_next_s  = bit_r;
        sreg_next_s = sreg_r;
        div_done_s  = (div_r == DIV_W'(CLK_DIV - 1));
        case (s_state_r)
            S_IDLE: begin
                if (start_s) begin
                    s_next_s    = S_LOW;
                    div_next_s  = '0;
                    bit_next_s  = '0;
                    sreg_next_s = snapshot_s;
                end else begin
                    s_next_s    = S_IDLE;
                end
            end
            S_LOW: begin
                if (div_done_s) begin
                    s_next_s   = S_HIGH;
                    div_next_s = '0;
                end else begin
                    div_next_s = div_r + DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (div_done_s) begin
                    div_next_s = '0;
                    if (bit_r == BIT_W'(BITS - 1)) begin
                        s_next_s = S_LATCH;
                    end else begin
                        s_next_s    = S_LOW;
                        bit_next_s  = bit_r + BIT_W'(1);
                        sreg_next_s = {sreg_r[BITS-2:0], 1'b0};
                    end
                end else begin
                    div_next_s = div_r + DIV_W'(1);
                end
            end
            S_LATCH: begin
                if (div_done_s) begin
                    s_next_s   = S_IDLE;
                    div_next_s = '0;
                end else begin
                    div_next_s = div_r + DIV_W'(1);
                end
            end
            default: s_next_s = S_IDLE;
        endcase
    end

    // State registers; serial outputs are registered from next-state so they align with the FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_state_r   <= C_IDLE;
            ptr_r       <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            s_state_r   <= S_IDLE;
            div_r       <= '0;
            bit_r       <= '0;
            sreg_r      <= '0;
            ref_pend_r  <= 1'b0;
            ser_data_r  <= 1'b0;
            ser_clk_r   <= 1'b0;
            ser_latch_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            c_state_r   <= c_next_s;
            ptr_r       <= ptr_next_s;
            count_r     <= count_next_s;
            overflow_r  <= overflow_next_s;
            s_state_r   <= s_next_s;
            div_r       <= div_next_s;
            bit_r       <= bit_next_s;
            sreg_r      <= sreg_next_s;
            ref_pend_r  <= ref_pend_next_s;
            ser_data_r  <= ((s_next_s == S_LOW) || (s_next_s == S_HIGH)) ?
                           sreg_next_s[BITS-1] : 1'b0;
            ser_clk_r   <= (s_next_s == S_HIGH);
            ser_latch_r <= (s_next_s == S_LATCH);
            busy_r      <= (c_next_s != C_IDLE) | (s_next_s != S_IDLE) | ref_pend_next_s;
        end
    end

    assign count_bcd = count_r;
    assign overflow  = overflow_r;
    assign ser_data  = ser_data_r;
    assign ser_clk   = ser_clk_r;
    assign ser_latch = ser_latch_r;
    assign busy      = busy_r;

endmodule
